// File: rtl/hit_scan_if.sv
// hit_scan_if: groups the bullet-pool / player-side signals of hit_scan_scheduler.
//   master : the surrounding logic (drives tick, player/bullet state; observes results)
//   slave  : hit_scan_scheduler
// Signals:
//   frame_tick, restart, init_health[3:0], my_en, p_x[9:0], p_y[9:0]
//   eb_x/eb_y[10*N_SLOTS-1:0] (slot i = bits [10i+9:10i]), eb_valid[N_SLOTS-1:0]
//   eb_kill[N_SLOTS-1:0], health[3:0], boom, scan_busy, scan_done, overrun
interface hit_scan_if #(
    parameter int unsigned N_SLOTS = 8
);
    logic                    frame_tick;
    logic                    restart;
    logic [3:0]              init_health;
    logic                    my_en;
    logic [9:0]              p_x;
    logic [9:0]              p_y;
    logic [10*N_SLOTS-1:0]   eb_x;
    logic [10*N_SLOTS-1:0]   eb_y;
    logic [N_SLOTS-1:0]      eb_valid;
    logic [N_SLOTS-1:0]      eb_kill;
    logic [3:0]              health;
    logic                    boom;
    logic                    scan_busy;
    logic                    scan_done;
    logic                    overrun;

    modport master (
        output frame_tick, restart, init_health, my_en, p_x, p_y, eb_x, eb_y, eb_valid,
        input  eb_kill, health, boom, scan_busy, scan_done, overrun
    );

    modport slave (
        input  frame_tick, restart, init_health, my_en, p_x, p_y, eb_x, eb_y, eb_valid,
        output eb_kill, health, boom, scan_busy, scan_done, overrun
    );
endinterface

// File: rtl/hit_scan_scheduler.sv
// hit_scan_scheduler: scans every enemy-bullet slot against the player hitbox once
// per frame with a single shared comparator, retires hit bullets, and owns the
// player health register (at most one point of damage per frame) and boom flag.
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset
//   bus        hit_scan_if.slave (frame_tick, restart, init_health, my_en, p_x, p_y,
//              eb_x, eb_y, eb_valid in; eb_kill, health, boom, scan_busy,
//              scan_done, overrun out)
// eb_kill is combinational: it pulses in the cycle its slot is tested.
// Optional feature macro: HIT_INVULN_EN (INVULN_FRAMES frames of post-hit immunity).
module hit_scan_scheduler #(
    parameter int unsigned N_SLOTS       = 8,
    parameter int unsigned Y_OFS         = 480,
    parameter int unsigned INVULN_FRAMES = 3
) (
    input  logic       clk,
    input  logic       rst,
    hit_scan_if.slave  bus
);

    localparam int unsigned IDX_W = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LATCH  = 2'd1;
    localparam logic [1:0] S_SCAN   = 2'd2;
    localparam logic [1:0] S_UPDATE = 2'd3;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [IDX_W-1:0]  idx;
    logic [10:0]       px;
    logic [10:0]       py;
    logic              alive;
    logic              hit_flag;
    logic [3:0]        health_q;
    logic              boom_q;
    logic              busy_q;
    logic              done_q;
    logic              overrun_q;

    logic [9:0]        slot_x [N_SLOTS];
    logic [9:0]        slot_y [N_SLOTS];
    logic signed [11:0] ex, ey, pxs, pys;
    logic              hit_c;
    logic              dmg_ok;
    logic              dmg_c;
    logic [N_SLOTS-1:0] kill_c;

    // Unpack the flat slot coordinate buses
    for (genvar g = 0; g < N_SLOTS; g++) begin : g_slot
        assign slot_x[g] = bus.eb_x[10*g +: 10];
        assign slot_y[g] = bus.eb_y[10*g +: 10];
    end

    // Hitbox test in 12-bit signed so px-10 / py-50 never wrap
    always_comb begin
        ex    = $signed({2'b00, slot_x[idx]});
        ey    = $signed({2'b00, slot_y[idx]});
        pxs   = $signed({1'b0, px});
        pys   = $signed({1'b0, py});
        hit_c = (state == S_SCAN) && bus.eb_valid[idx] && alive &&
                (ex >= pxs - 12'sd10) && (ex < pxs + 12'sd50) &&
                (ey >= pys - 12'sd50) && (ey < pys + 12'sd40);
    end

    // Retire pulse for the slot under test; restart swallows it
    always_comb begin
        kill_c = '0;
        if (hit_c && !bus.restart) begin
            kill_c[idx] = 1'b1;
        end
    end

    assign dmg_c = (state == S_UPDATE) && hit_flag && dmg_ok;

`ifdef HIT_INVULN_EN
    logic [3:0] invuln;

    assign dmg_ok = (invuln == 4'd0);

    // Immunity window: reload on a damaging frame, count down on the others
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            invuln <= 4'd0;
        end else if (bus.restart) begin
            invuln <= 4'd0;
        end else if (state == S_UPDATE) begin
            if (dmg_c) begin
                invuln <= 4'(INVULN_FRAMES);
            end else if (invuln != 4'd0) begin
                invuln <= invuln - 4'd1;
            end
        end
    end
`else
    // Without the immunity window every hit frame is damaging
    logic unused_cfg;
    assign dmg_ok     = 1'b1;
    assign unused_cfg = ^4'(INVULN_FRAMES);
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        if (bus.restart) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:   if (bus.frame_tick) state_nxt = S_LATCH;
                S_LATCH:  state_nxt = S_SCAN;
                S_SCAN:   if (idx == IDX_W'(N_SLOTS - 1)) state_nxt = S_UPDATE;
                S_UPDATE: state_nxt = S_IDLE;
                default:  state_nxt = S_IDLE;
            endcase
        end
    end

    // Datapath, health and status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx       <= '0;
            px        <= '0;
            py        <= '0;
            alive     <= 1'b0;
            hit_flag  <= 1'b0;
            health_q  <= bus.init_health;
            boom_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            busy_q <= (state_nxt != S_IDLE);
            done_q <= (state_nxt == S_UPDATE);
            if (bus.restart) begin
                idx       <= '0;
                hit_flag  <= 1'b0;
                alive     <= 1'b0;
                health_q  <= bus.init_health;
                boom_q    <= 1'b0;
                overrun_q <= 1'b0;
            end else begin
                boom_q <= (health_q == 4'd0);
                if (bus.frame_tick && (state != S_IDLE)) begin
                    overrun_q <= 1'b1;
                end
                case (state)
                    S_LATCH: begin
                        px       <= {1'b0, bus.p_x};
                        py       <= 11'({1'b0, bus.p_y} + 11'(Y_OFS));
                        alive    <= bus.my_en && (health_q != 4'd0);
                        idx      <= '0;
                        hit_flag <= 1'b0;
                    end
                    S_SCAN: begin
                        idx <= idx + IDX_W'(1);
                        if (hit_c) begin
                            hit_flag <= 1'b1;
                        end
                    end
                    S_UPDATE: begin
                        if (dmg_c && (health_q != 4'd0)) begin
                            health_q <= health_q - 4'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.eb_kill   = kill_c;
    assign bus.health    = health_q;
    assign bus.boom      = boom_q;
    assign bus.scan_busy = busy_q;
    assign bus.scan_done = done_q;
    assign bus.overrun   = overrun_q;

endmodule
